// File: rtl/wb_pkg.sv
// Shared widths, entry type and reset constants for the register write-back buffer.
package wb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [ADDR_W-1:0] ADDR_RST  = '0;
    localparam logic [DATA_W-1:0] DATA_RST  = '0;
    localparam wb_entry_t         ENTRY_RST = '{addr: ADDR_RST, data: DATA_RST};

endpackage

// File: rtl/wb_match.sv
// Youngest-wins search of the buffered entries for one register address.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  entry_valid,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest slot toward wr_ptr so a later match overrides an earlier one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hit  = 1'b0;
        data = DATA_RST;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PTR_W'(k);
            if (entry_valid[idx] && (entries[idx].addr == lk_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_buffer.sv
// FIFO of pending register-file writes, drained one per cycle unless drain_hold is set.
// Optional read-port bypass of pending data is built when WB_BYPASS_EN is defined.
module reg_writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       drain_hold,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    input  logic [ADDR_W-1:0]          lk_addr_a,
    input  logic [ADDR_W-1:0]          lk_addr_b,
    output logic                       lk_hit_a,
    output logic [DATA_W-1:0]          lk_data_a,
    output logic                       lk_hit_b,
    output logic [DATA_W-1:0]          lk_data_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = rf_write_enable;

    assign rf_write_enable = !empty && !drain_hold;
    assign rf_write_addr   = empty ? ADDR_RST : mem[rd_ptr].addr;
    assign rf_write_data   = empty ? DATA_RST : mem[rd_ptr].data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; count and entry_valid alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data};
        end
    end

`ifdef WB_BYPASS_EN
    wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_a (
        .entries     (mem),
        .entry_valid (entry_valid),
        .wr_ptr      (wr_ptr),
        .lk_addr     (lk_addr_a),
        .hit         (lk_hit_a),
        .data        (lk_data_a)
    );

    wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_b (
        .entries     (mem),
        .entry_valid (entry_valid),
        .wr_ptr      (wr_ptr),
        .lk_addr     (lk_addr_b),
        .hit         (lk_hit_b),
        .data        (lk_data_b)
    );
`else
    logic unused_lookup;

    // Valid bits and lookup addresses only feed the bypass search.
    assign unused_lookup = ^{entry_valid, lk_addr_a, lk_addr_b};
    assign lk_hit_a      = 1'b0;
    assign lk_data_a     = DATA_RST;
    assign lk_hit_b      = 1'b0;
    assign lk_data_b     = DATA_RST;
`endif

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Self-checking bench for reg_writeback_buffer against a queue-based model of pending writes.
module tb_reg_writeback_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              drain_hold;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] lk_addr_a;
    logic [ADDR_W-1:0] lk_addr_b;
    logic              lk_hit_a;
    logic [DATA_W-1:0] lk_data_a;
    logic              lk_hit_b;
    logic [DATA_W-1:0] lk_data_b;
    logic [2:0]        count;
    logic              empty;
    logic              full;

    int checks   = 0;
    int failures = 0;

    wb_entry_t model_q[$];

    reg_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .drain_hold      (drain_hold),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .lk_addr_a       (lk_addr_a),
        .lk_addr_b       (lk_addr_b),
        .lk_hit_a        (lk_hit_a),
        .lk_data_a       (lk_data_a),
        .lk_hit_b        (lk_hit_b),
        .lk_data_b       (lk_data_b),
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    always #5 clk = ~clk;

    // Youngest pending write to an address; the bypass is absent in the default build.
    function automatic void model_lookup(input logic [ADDR_W-1:0] a, output logic hit,
                                         output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_BYPASS_EN
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].addr == a) begin
                hit = 1'b1;
                d   = model_q[i].data;
                break;
            end
        end
`endif
    endfunction

    // Advance one clock edge, applying the buffer's rules to the model with the current inputs.
    task automatic tick();
        bit do_pop;
        bit do_push;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() > 0) && !drain_hold;
            do_push = in_valid && (model_q.size() < DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back('{addr: in_addr, data: in_data});
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        drain_hold = 1'b0;
        lk_addr_a  = '0;
        lk_addr_b  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({empty, in_ready, full, rf_write_enable, count} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_flags got e=%b r=%b f=%b we=%b cnt=%0d want e=1 r=1 f=0 we=0 cnt=0",
                     empty, in_ready, full, rf_write_enable, count);
        end
        checks++;
        if ({rf_write_addr, rf_write_data, lk_hit_a, lk_hit_b, lk_data_a, lk_data_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%h data=%h hits=%b%b lk=%h/%h want all zero",
                     rf_write_addr, rf_write_data, lk_hit_a, lk_hit_b, lk_data_a, lk_data_b);
        end
        tick();
    endtask

    task automatic test_single_write();
        in_valid = 1'b1;
        in_addr  = 4'd3;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 4'd3, 8'h5A}) begin
            failures++;
            $display("FAIL single_present got we=%b addr=%h data=%h want we=1 addr=3 data=5a",
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        tick();
        checks++;
        if ({empty, rf_write_enable, count} !== {1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL single_drained got e=%b we=%b cnt=%0d want e=1 we=0 cnt=0",
                     empty, rf_write_enable, count);
        end
    endtask

    task automatic test_fill_and_drain();
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_addr  = ADDR_W'(i);
            in_data  = DATA_W'(8'h11 * i);
            tick();
        end
        in_addr = 4'd5;
        in_data = 8'h55;
        #1;
        checks++;
        if ({full, in_ready, rf_write_enable, count} !== {1'b1, 1'b0, 1'b0, 3'd4}) begin
            failures++;
            $display("FAIL fill_full got f=%b r=%b we=%b cnt=%0d want f=1 r=0 we=0 cnt=4",
                     full, in_ready, rf_write_enable, count);
        end
        tick();
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL fill_fifth_rejected got cnt=%0d want 4", count);
        end
        in_valid   = 1'b0;
        drain_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if ({rf_write_enable, rf_write_addr, rf_write_data, count} !==
                {1'b1, ADDR_W'(i), DATA_W'(8'h11 * i), 3'(5 - i)}) begin
                failures++;
                $display("FAIL drain_%0d got we=%b addr=%h data=%h cnt=%0d want we=1 addr=%h data=%h cnt=%0d",
                         i, rf_write_enable, rf_write_addr, rf_write_data, count, i, 8'h11 * i, 5 - i);
            end
            tick();
        end
        checks++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL drain_done got e=%b cnt=%0d want e=1 cnt=0", empty, count);
        end
    endtask

    task automatic test_bypass();
        logic exp_hit_a;
        logic exp_hit_b;
        logic [DATA_W-1:0] exp_da;
        logic [DATA_W-1:0] exp_db;
        drain_hold = 1'b1;
        in_valid   = 1'b1;
        in_addr    = 4'd7;
        in_data    = 8'hAA;
        tick();
        in_data = 8'hBB;
        tick();
        in_valid  = 1'b0;
        lk_addr_a = 4'd7;
        lk_addr_b = 4'd2;
        #1;
`ifdef WB_BYPASS_EN
        exp_hit_a = 1'b1;
        exp_da    = 8'hBB;
`else
        exp_hit_a = 1'b0;
        exp_da    = 8'h00;
`endif
        exp_hit_b = 1'b0;
        exp_db    = 8'h00;
        checks++;
        if ({lk_hit_a, lk_data_a} !== {exp_hit_a, exp_da}) begin
            failures++;
            $display("FAIL bypass_a got hit=%b data=%h want hit=%b data=%h", lk_hit_a, lk_data_a, exp_hit_a, exp_da);
        end
        checks++;
        if ({lk_hit_b, lk_data_b} !== {exp_hit_b, exp_db}) begin
            failures++;
            $display("FAIL bypass_b got hit=%b data=%h want hit=0 data=00", lk_hit_b, lk_data_b);
        end
        drain_hold = 1'b0;
        tick();
        // Remaining entry (7,BB) is being popped this cycle and must still be visible.
        #1;
        model_lookup(4'd7, exp_hit_a, exp_da);
        checks++;
        if ({lk_hit_a, lk_data_a} !== {exp_hit_a, exp_da}) begin
            failures++;
            $display("FAIL bypass_popping got hit=%b data=%h want hit=%b data=%h", lk_hit_a, lk_data_a, exp_hit_a, exp_da);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        drain_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = ADDR_W'(8 + i);
            in_data  = DATA_W'(8'hC0 + i);
            tick();
        end
        drain_hold = 1'b0;
        in_addr    = 4'hF;
        in_data    = 8'hFF;
        #1;
        checks++;
        if ({in_ready, rf_write_enable, rf_write_addr} !== {1'b0, 1'b1, 4'd8}) begin
            failures++;
            $display("FAIL full_pushpop_pre got r=%b we=%b addr=%h want r=0 we=1 addr=8",
                     in_ready, rf_write_enable, rf_write_addr);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({count, rf_write_addr, rf_write_data} !== {3'd3, 4'd9, 8'hC1}) begin
            failures++;
            $display("FAIL full_pushpop_post got cnt=%0d addr=%h data=%h want cnt=3 addr=9 data=c1",
                     count, rf_write_addr, rf_write_data);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL full_pushpop_drain got e=%b cnt=%0d want e=1 cnt=0 (rejected entry must not appear)",
                     empty, count);
        end
    endtask

    task automatic test_reset_mid_drain();
        drain_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_addr  = ADDR_W'(i + 1);
            in_data  = DATA_W'(8'h70 + i);
            tick();
        end
        drain_hold = 1'b0;
        reset      = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({count, rf_write_enable, empty, lk_hit_a, lk_hit_b} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got cnt=%0d we=%b e=%b hits=%b%b want cnt=0 we=0 e=1 hits=00",
                     count, rf_write_enable, empty, lk_hit_a, lk_hit_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rf_write_enable !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cycle %0d got we=%b want 0", i, rf_write_enable);
            end
        end
    endtask

    task automatic test_random();
        logic exp_hit_a;
        logic exp_hit_b;
        logic [DATA_W-1:0] exp_da;
        logic [DATA_W-1:0] exp_db;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        int n;
        int rand_fail;
        rand_fail = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset      = ($urandom_range(0, 63) == 0);
            in_valid   = ($urandom_range(0, 99) < 60);
            drain_hold = ($urandom_range(0, 99) < 40);
            in_addr    = ADDR_W'($urandom_range(0, 5));
            in_data    = DATA_W'($urandom);
            lk_addr_a  = ADDR_W'($urandom_range(0, 5));
            lk_addr_b  = ADDR_W'($urandom_range(0, 5));
            #1;
            n        = model_q.size();
            exp_addr = (n > 0) ? model_q[0].addr : '0;
            exp_data = (n > 0) ? model_q[0].data : '0;
            model_lookup(lk_addr_a, exp_hit_a, exp_da);
            model_lookup(lk_addr_b, exp_hit_b, exp_db);
            checks++;
            if ({count, empty, full, in_ready, rf_write_enable, rf_write_addr, rf_write_data,
                 lk_hit_a, lk_data_a, lk_hit_b, lk_data_b} !==
                {3'(n), n == 0, n == DEPTH, n != DEPTH, (n > 0) && !drain_hold, exp_addr, exp_data,
                 exp_hit_a, exp_da, exp_hit_b, exp_db}) begin
                failures++;
                rand_fail++;
                if (rand_fail <= 10)
                    $display("FAIL random cyc %0d got cnt=%0d we=%b a=%h d=%h ha=%b da=%h hb=%b db=%h want cnt=%0d we=%b a=%h d=%h ha=%b da=%h hb=%b db=%h",
                             cyc, count, rf_write_enable, rf_write_addr, rf_write_data, lk_hit_a, lk_data_a,
                             lk_hit_b, lk_data_b, n, (n > 0) && !drain_hold, exp_addr, exp_data,
                             exp_hit_a, exp_da, exp_hit_b, exp_db);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_fill_and_drain();
        test_bypass();
        test_full_push_pop();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
